status_led_collector: RTL and testbench
=======================================

# status_led_collector

Builds the 16-bit front-panel status word that the startup LED display shows once its power-on light pattern has finished, and generates that display's RUN strobe. Single-cycle event pulses such as L1A, injection and link errors are stretched to human-visible lengths on a millisecond time base. Level signals are registered, and a heartbeat is added. The block sits directly upstream of the startup display, driving its DCFEB_STATUS and RUN inputs.

## Interface
- PRESCALE, 40000: CLK cycles per millisecond tick (2..2^20).
- STRETCH_MS, 50: minimum visible length of a stretched event, in ms (1..255).
- RUN_DELAY_MS, 2000: time CFG_DONE must be held high before RUN asserts, in ms (0..65535).
- HB_MS, 500: heartbeat half-period, in ms (1..65535).
- CLK  in  1  system clock; everything is in this one clock domain.
- RST  in  1  reset, synchronous and active-high.
- CFG_DONE  in  1  configuration/initialisation complete (level).
- EVT  in  12  event pulses, each active for one CLK cycle or longer.
- LVL  in  2  status levels, shown directly on the display.
- CLR_STICKY  in  1  one-cycle pulse that clears sticky bits (only meaningful with the configuration macro).
- RUN  out  1  feeds the display's RUN input.
- DCFEB_STATUS  out  16  status word.
- TICK_1MS  out  1  one-cycle strobe per millisecond.

## Operation
- **Prescaler**
  - Counter runs 0..PRESCALE-1, then wraps to 0.
  - TICK_1MS is registered and is high for the one cycle after the counter reaches PRESCALE-1.
- **Status word layout**
  - DCFEB_STATUS[0] = heartbeat.
  - DCFEB_STATUS[1] = RUN.
  - DCFEB_STATUS[3:2] = LVL, registered once.
  - DCFEB_STATUS[15:4] = stretched EVT[11:0].
- **Stretcher (one per EVT bit)**
  - 8-bit down-counter.
  - EVT high loads STRETCH_MS.
  - Otherwise the counter decrements on each TICK_1MS while nonzero.
  - A load beats a decrement in the same cycle, so re-triggering extends the pulse.
  - Output bit is registered (counter != 0).
- **RUN generator**
  - 16-bit tick counter, cleared whenever CFG_DONE is low.
  - While CFG_DONE is high it increments on TICK_1MS and saturates at RUN_DELAY_MS.
  - RUN is registered and equals (CFG_DONE && count == RUN_DELAY_MS).
  - When CFG_DONE falls, RUN drops the next cycle and the count restarts.
- **Heartbeat**
  - 16-bit tick counter; on the tick where it reaches HB_MS-1 it resets to 0 and the heartbeat toggles.
  - It runs independent of RUN.
- **Reset**
  - All counters are cleared.
  - TICK_1MS=0, RUN=0, DCFEB_STATUS=16'h0000, heartbeat=0.
  - Reset asserted mid-stretch or mid-delay aborts it immediately; outputs are 0 on the cycle after RST is sampled.

## Timing
- EVT sampled high at edge n gives DCFEB_STATUS bit high from edge n+1.
- A stretched bit stays high for STRETCH_MS-1 to STRETCH_MS ms, depending on prescaler phase. It is never shorter than (STRETCH_MS-1)*PRESCALE+1 cycles.
- LVL to DCFEB_STATUS[3:2]: 1 cycle.
- RUN_DELAY_MS=0: RUN rises 1 cycle after CFG_DONE is sampled high.
- RUN_DELAY_MS>0: RUN rises 1 cycle after the RUN_DELAY_MS-th tick seen with CFG_DONE high.
- EVT held high continuously keeps the bit high; it falls STRETCH_MS ticks after EVT is released.

## Configuration
- **STATUS_STICKY_EN**
  - When defined, bits [15:12] (EVT[11:8], the error events) are sticky: once set they stay high until a CLR_STICKY pulse.
  - CLR_STICKY clears them only if the stretch counter is also 0.
  - If CLR_STICKY and the EVT bit are high in the same cycle, the bit stays set.
  - RST always clears the sticky bits.
- **Without the macro**
  - Bits [15:12] behave as ordinary stretched bits.
  - CLR_STICKY is ignored.

## Structure
- **Package status_led_pkg**
  - Bit-index constants: HB_BIT=0, RUN_BIT=1, LVL_LSB=2, EVT_LSB=4, STICKY_LSB=12.
  - Constants: NUM_EVT=12, STRETCH_W=8, MS_CNT_W=16.
- **Sub-module pulse_stretch**
  - Parameters: STRETCH_MS, STICKY.
  - Ports: CLK, RST, TICK, EVT, CLR, Q.
  - Instantiated 12 times with a generate loop.
- Prescaler, RUN generator and heartbeat live in the top level.

## Test plan
Benches use PRESCALE=4, STRETCH_MS=3, RUN_DELAY_MS=5, HB_MS=2.
- **Reset:** hold RST for 3 cycles with all inputs toggling -> RUN=0, DCFEB_STATUS=0, TICK_1MS=0; the first tick appears 4 cycles after RST drops.
- **Single event:** 1-cycle pulse on EVT[0] -> DCFEB_STATUS[4] high the next cycle and low after the 3rd subsequent tick (9..12 cycles); no other bit changes.
- **Retrigger:** pulse EVT[5] again 6 cycles after the first -> DCFEB_STATUS[9] is reloaded and stays high until 3 ticks after the second pulse.
- **RUN:**
  - CFG_DONE raised -> RUN and DCFEB_STATUS[1] rise 1 cycle after the 5th tick.
  - Dropping CFG_DONE for one cycle mid-count restarts the 5-tick wait.
- **Heartbeat:** free-running -> DCFEB_STATUS[0] toggles every 2 ticks (8 cycles).
- **STATUS_STICKY_EN:**
  - With the macro defined, a pulse on EVT[9] -> DCFEB_STATUS[13] stays high beyond 3 ticks.
  - CLR_STICKY after stretch expiry clears it the next cycle.
  - CLR_STICKY coincident with EVT[9] leaves it set.

Source files
------------

// File: rtl/status_led_pkg.sv
// -----------------------------------------------------------------------------
// status_led_pkg
// Shared constants for the front-panel status word collector: bit positions
// inside DCFEB_STATUS and the widths of the millisecond-domain counters.
// No ports (package).
// -----------------------------------------------------------------------------
package status_led_pkg;

  // Bit positions inside the 16-bit status word
  localparam int HB_BIT     = 0;
  localparam int RUN_BIT    = 1;
  localparam int LVL_LSB    = 2;
  localparam int EVT_LSB    = 4;
  localparam int STICKY_LSB = 12;

  // Sizes
  localparam int NUM_EVT    = 12;
  localparam int STRETCH_W  = 8;
  localparam int MS_CNT_W   = 16;

endpackage

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Stretches a short event pulse to at least STRETCH_MS millisecond ticks so it
// is visible on an LED. With STICKY set, the output latches until cleared.
//
// Ports:
//   CLK  in  system clock
//   RST  in  synchronous active-high reset
//   TICK in  one-cycle millisecond strobe
//   EVT  in  event input (pulse or level)
//   CLR  in  sticky clear pulse (used only when STICKY=1)
//   Q    out registered stretched output
// -----------------------------------------------------------------------------
module pulse_stretch
  import status_led_pkg::*;
#(
  parameter int STRETCH_MS = 50,
  parameter bit STICKY     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic TICK,
  input  logic EVT,
  input  logic CLR,
  output logic Q
);

  localparam logic [STRETCH_W-1:0] LOAD_VAL = STRETCH_W'(STRETCH_MS);

  logic [STRETCH_W-1:0] r_cnt;
  logic                 r_q;
  logic                 w_cnt_nz;

  assign w_cnt_nz = (r_cnt != '0);

  // A new event reloads the counter even on a tick, so retriggers extend.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (EVT) begin
      r_cnt <= LOAD_VAL;
    end else if (TICK && w_cnt_nz) begin
      r_cnt <= r_cnt - STRETCH_W'(1);
    end
  end

  // Sticky: a clear only takes effect once the stretch has run out (the
  // w_cnt_nz term re-sets the bit otherwise) and never while EVT is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= 1'b0;
    end else if (STICKY) begin
      r_q <= w_cnt_nz | (r_q & ~(CLR & ~EVT));
    end else begin
      r_q <= w_cnt_nz;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/status_led_collector.sv
// -----------------------------------------------------------------------------
// status_led_collector
// Builds the 16-bit front-panel status word for the startup LED display and
// its RUN strobe. Event pulses are stretched on a millisecond time base, level
// inputs are registered, and a heartbeat is added.
//
// Status word: [0] heartbeat, [1] RUN, [3:2] LVL, [15:4] stretched EVT[11:0].
//
// Ports:
//   CLK          in   system clock (single domain)
//   RST          in   synchronous active-high reset
//   CFG_DONE     in   configuration complete level
//   EVT[11:0]    in   event pulses
//   LVL[1:0]     in   status levels
//   CLR_STICKY   in   clears sticky error bits (STATUS_STICKY_EN builds only)
//   RUN          out  display RUN input
//   DCFEB_STATUS out  status word
//   TICK_1MS     out  one-cycle strobe per millisecond
//
// Build option: define STATUS_STICKY_EN to make bits [15:12] (EVT[11:8])
// sticky until CLR_STICKY; otherwise they are ordinary stretched bits.
// -----------------------------------------------------------------------------
module status_led_collector
  import status_led_pkg::*;
#(
  parameter int PRESCALE     = 40000,
  parameter int STRETCH_MS   = 50,
  parameter int RUN_DELAY_MS = 2000,
  parameter int HB_MS        = 500
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CFG_DONE,
  input  logic [NUM_EVT-1:0] EVT,
  input  logic [1:0]         LVL,
  input  logic               CLR_STICKY,
  output logic               RUN,
  output logic [15:0]        DCFEB_STATUS,
  output logic               TICK_1MS
);

  localparam int                  PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam logic [MS_CNT_W-1:0] RUN_TARGET = MS_CNT_W'(RUN_DELAY_MS);
  localparam logic [MS_CNT_W-1:0] HB_LAST    = MS_CNT_W'(HB_MS - 1);

`ifdef STATUS_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  // Millisecond prescaler
  logic [PRE_W-1:0] r_pre;
  logic             r_tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (r_pre == PRE_LAST) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pre  <= r_pre + PRE_W'(1);
      r_tick <= 1'b0;
    end
  end

  // RUN generator: counts ticks while CFG_DONE is held, saturating at target
  logic [MS_CNT_W-1:0] r_run_cnt;
  logic                r_run;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_run_cnt <= '0;
      r_run     <= 1'b0;
    end else begin
      if (!CFG_DONE) begin
        r_run_cnt <= '0;
      end else if (r_tick && (r_run_cnt != RUN_TARGET)) begin
        r_run_cnt <= r_run_cnt + MS_CNT_W'(1);
      end
      r_run <= CFG_DONE && (r_run_cnt == RUN_TARGET);
    end
  end

  // Heartbeat: toggles every HB_MS ticks
  logic [MS_CNT_W-1:0] r_hb_cnt;
  logic                r_hb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_tick) begin
      if (r_hb_cnt == HB_LAST) begin
        r_hb_cnt <= '0;
        r_hb     <= ~r_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + MS_CNT_W'(1);
      end
    end
  end

  // Level inputs
  logic [1:0] r_lvl;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lvl <= '0;
    end else begin
      r_lvl <= LVL;
    end
  end

  // Event stretchers
  logic               w_clr;
  logic [NUM_EVT-1:0] w_evt_q;

`ifdef STATUS_STICKY_EN
  assign w_clr = CLR_STICKY;
`else
  logic w_unused_clr;
  assign w_unused_clr = CLR_STICKY;
  assign w_clr        = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt
    localparam bit IS_STICKY = STICKY_EN && (gi >= (STICKY_LSB - EVT_LSB));

    pulse_stretch #(
      .STRETCH_MS (STRETCH_MS),
      .STICKY     (IS_STICKY)
    ) u_stretch (
      .CLK  (CLK),
      .RST  (RST),
      .TICK (r_tick),
      .EVT  (EVT[gi]),
      .CLR  (w_clr),
      .Q    (w_evt_q[gi])
    );
  end

  // Outputs (all register-driven)
  assign TICK_1MS                           = r_tick;
  assign RUN                                = r_run;
  assign DCFEB_STATUS[HB_BIT]               = r_hb;
  assign DCFEB_STATUS[RUN_BIT]              = r_run;
  assign DCFEB_STATUS[LVL_LSB+1:LVL_LSB]    = r_lvl;
  assign DCFEB_STATUS[EVT_LSB+NUM_EVT-1:EVT_LSB] = w_evt_q;

endmodule

// File: tb/tb_status_led_collector.sv
// -----------------------------------------------------------------------------
// tb_status_led_collector
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a negedge monitor compares DUT outputs against entries due on the
// current edge. Edge numbering: reset edges are -2..0, edge 1 is the first
// rising edge with RST low. Observed vector is {RUN, TICK_1MS, DCFEB_STATUS}.
// -----------------------------------------------------------------------------
module tb_status_led_collector;

  localparam int PRESCALE     = 4;
  localparam int STRETCH_MS   = 3;
  localparam int RUN_DELAY_MS = 5;
  localparam int HB_MS        = 2;

  localparam logic [17:0] M_ALL  = 18'h3FFFF;
  localparam logic [17:0] M_RUN  = 18'h20000;
  localparam logic [17:0] M_TICK = 18'h10000;
  localparam logic [17:0] M_HB   = 18'h00001;
  localparam logic [17:0] M_RUNB = 18'h20002;
  localparam logic [17:0] M_LVL  = 18'h0000C;
  localparam logic [17:0] M_B4   = 18'h00010;
  localparam logic [17:0] M_B9   = 18'h00200;
  localparam logic [17:0] M_B13  = 18'h02000;

`ifdef STATUS_STICKY_EN
  localparam logic [17:0] STK13 = 18'h02000;
`else
  localparam logic [17:0] STK13 = 18'h00000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_done;
  logic [11:0] evt;
  logic [1:0]  lvl;
  logic        clr;
  logic        run;
  logic [15:0] status;
  logic        tick;

  int r = -3;
  int applied = 0;
  int miscompares = 0;

  typedef struct {
    int          n;
    string       name;
    logic [17:0] mask;
    logic [17:0] exp;
  } sb_t;

  sb_t sb[$];

  status_led_collector #(
    .PRESCALE     (PRESCALE),
    .STRETCH_MS   (STRETCH_MS),
    .RUN_DELAY_MS (RUN_DELAY_MS),
    .HB_MS        (HB_MS)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .CFG_DONE     (cfg_done),
    .EVT          (evt),
    .LVL          (lvl),
    .CLR_STICKY   (clr),
    .RUN          (run),
    .DCFEB_STATUS (status),
    .TICK_1MS     (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) r <= r + 1;

  // Monitor: compare every scoreboard entry due on the edge just taken
  always @(negedge clk) begin
    logic [17:0] obs;
    obs = {run, tick, status};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].n == r) begin
        applied++;
        if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
          miscompares++;
          $display("FAIL %s @edge %0d: got %05h want %05h (mask %05h)",
                   sb[i].name, r, obs & sb[i].mask, sb[i].exp & sb[i].mask, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int n, input string nm,
                           input logic [17:0] m, input logic [17:0] e);
    sb_t s;
    s.n = n; s.name = nm; s.mask = m; s.exp = e;
    sb.push_back(s);
  endtask

  // Returns 1 ns after edge n
  task automatic wait_edge(input int n);
    while (r < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_done = 1'b1; evt = 12'hFFF; lvl = 2'b11; clr = 1'b1;

    // Reset with toggling inputs
    for (int k = -2; k <= 0; k++) expect_at(k, "reset_all_zero", M_ALL, 18'h0);
    wait_edge(-2);
    cfg_done = 1'b0; evt = 12'h5A5; lvl = 2'b01; clr = 1'b0;
    wait_edge(-1);
    cfg_done = 1'b1; evt = 12'hA5A; lvl = 2'b10; clr = 1'b1;
    wait_edge(0);
    rst = 1'b0; cfg_done = 1'b0; evt = '0; lvl = '0; clr = 1'b0;

    // First tick 4 cycles after reset release; heartbeat every 8 cycles
    expect_at(1, "tick_e1", M_TICK, 18'h0);
    expect_at(3, "tick_e3", M_TICK, 18'h0);
    expect_at(4, "tick_first", M_TICK, M_TICK);
    expect_at(5, "tick_one_cycle", M_TICK, 18'h0);
    expect_at(8, "hb_low", M_HB, 18'h0);
    expect_at(9, "hb_rise", M_HB, M_HB);
    expect_at(16, "hb_hold", M_HB, M_HB);
    expect_at(17, "hb_fall", M_HB, 18'h0);
    expect_at(25, "hb_rise2", M_HB, M_HB);

    // Single event on EVT[0]
    expect_at(6, "evt0_before", M_B4, 18'h0);
    expect_at(7, "evt0_only_bit4", 18'h3FFFE, 18'h00010);
    expect_at(17, "evt0_hold", M_B4, M_B4);
    expect_at(18, "evt0_fall", M_B4, 18'h0);
    wait_edge(5);
    if (tick !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_tick_e5: got %b want 0", tick);
    end
    evt[0] = 1'b1;
    wait_edge(6);  evt[0] = 1'b0;

    // Levels
    expect_at(9,  "lvl_00", M_LVL, 18'h0);
    expect_at(10, "lvl_10", M_LVL, 18'h8);
    expect_at(11, "lvl_01", M_LVL, 18'h4);
    expect_at(12, "lvl_00b", M_LVL, 18'h0);
    wait_edge(9);
    if (status[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_hb_e9: got %b want 1", status[0]);
    end
    lvl = 2'b10;
    wait_edge(10); lvl = 2'b01;
    wait_edge(11); lvl = 2'b00;

    // Retrigger EVT[5] six cycles after the first pulse
    expect_at(20, "retrig_before", M_B9, 18'h0);
    expect_at(21, "retrig_rise", M_B9, M_B9);
    expect_at(30, "retrig_extended", M_B9, M_B9);
    expect_at(37, "retrig_hold", M_B9, M_B9);
    expect_at(38, "retrig_fall", M_B9, 18'h0);
    wait_edge(19); evt[5] = 1'b1;
    wait_edge(20); evt[5] = 1'b0;
    wait_edge(25); evt[5] = 1'b1;
    wait_edge(26); evt[5] = 1'b0;

    // RUN: 5-tick wait restarted by a one-cycle CFG_DONE drop
    expect_at(58, "run_restarted", M_RUNB, 18'h0);
    expect_at(69, "run_not_yet", M_RUNB, 18'h0);
    expect_at(70, "run_rise", M_RUNB, M_RUNB);
    expect_at(74, "run_hold", M_RUNB, M_RUNB);
    expect_at(75, "run_drop", M_RUNB, 18'h0);
    wait_edge(39); cfg_done = 1'b1;
    wait_edge(49); cfg_done = 1'b0;
    wait_edge(50); cfg_done = 1'b1;
    wait_edge(74);
    if ((run !== 1'b1) || (status[1] !== 1'b1)) begin
      miscompares++;
      $display("FAIL direct_run_e74: got run=%b status[1]=%b want 1/1", run, status[1]);
    end
    cfg_done = 1'b0;

    // Error event EVT[9] -> bit 13 (sticky in STATUS_STICKY_EN builds)
    expect_at(80, "err_before", M_B13, 18'h0);
    expect_at(81, "err_rise", M_B13, M_B13);
    expect_at(89, "err_hold", M_B13, M_B13);
    expect_at(90, "err_after_stretch", M_B13, STK13);
    expect_at(99, "err_late", M_B13, STK13);
    expect_at(100, "err_cleared", M_B13, 18'h0);
    wait_edge(79); evt[9] = 1'b1;
    wait_edge(80); evt[9] = 1'b0;
    wait_edge(99); clr = 1'b1;
    wait_edge(100); clr = 1'b0;

    expect_at(106, "err2_rise", M_B13, M_B13);
    expect_at(107, "err2_clr_while_counting", M_B13, M_B13);
    expect_at(118, "err2_after_stretch", M_B13, STK13);
    expect_at(120, "err3_clr_with_evt", M_B13, STK13);
    expect_at(121, "err3_rise", M_B13, M_B13);
    expect_at(130, "err3_after_stretch", M_B13, STK13);
    expect_at(131, "err3_cleared", M_B13, 18'h0);
    wait_edge(104); evt[9] = 1'b1;
    wait_edge(105); evt[9] = 1'b0;
    wait_edge(106); clr = 1'b1;
    wait_edge(107); clr = 1'b0;
    wait_edge(119); evt[9] = 1'b1; clr = 1'b1;
    wait_edge(120); evt[9] = 1'b0; clr = 1'b0;
    wait_edge(130); clr = 1'b1;
    wait_edge(131); clr = 1'b0;

    // Reset mid-stretch with RUN high
    expect_at(153, "run2_not_yet", M_RUN, 18'h0);
    expect_at(154, "run2_rise", M_RUNB, M_RUNB);
    expect_at(155, "pre_reset_state", 18'h20022, 18'h20022);
    expect_at(156, "midreset_zero", M_ALL, 18'h0);
    expect_at(157, "midreset_zero2", M_ALL, 18'h0);
    expect_at(158, "post_reset_zero", M_ALL, 18'h0);
    wait_edge(134); cfg_done = 1'b1;
    wait_edge(149); evt[1] = 1'b1;
    wait_edge(150); evt[1] = 1'b0;
    wait_edge(155); rst = 1'b1;
    wait_edge(157); rst = 1'b0; cfg_done = 1'b0;

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 40 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      applied++;
      miscompares++;
      $display("FAIL %s @edge %0d: never checked, want %05h", sb[0].name, sb[0].n, sb[0].exp);
      sb.delete(0);
    end

    if (applied == 0) begin
      miscompares++;
      $display("FAIL no scoreboard vectors were applied");
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", r);
    $fatal(1, "watchdog");
  end

endmodule
